// File: rtl/booth_pkg.sv
// Shared types and encodings for the radix-2 Booth multiplier controller.
package booth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDX,
    S_LDY,
    S_EVAL,
    S_SHIFT,
    S_OUT_HI,
    S_OUT_LO
  } state_e;

  // {Y[0], Y[-1]} patterns that require an arithmetic step
  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

  // aBarS encodings: low selects A + X, high selects A - X
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth sequence: cleared before the first
// iteration, bumped once per shift, flags the final iteration.
module booth_iter_counter #(
  parameter int N     = 6,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last iteration is being shifted when the count still reads N-1
  assign last = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier datapath: loads X then Y,
// runs N evaluate/shift iterations, then presents the product in two beats
// (A high half, then Y low half). Holds no data itself.
module booth_controller
  import booth_pkg::*;
#(
  parameter int N     = 6,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Y0YminusOne,
  output logic       ready,
  output logic       out_valid,
  output logic       out_hi,
  output logic       done,
  output logic       ldX,
  output logic       ldY,
  output logic       ldA,
  output logic       initA,
  output logic       initYminusOne,
  output logic       aBarS,
  output logic       shRA,
  output logic       shRY,
  output logic       ldYminusOne,
  output logic       selL,
  output logic       selR
);

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  booth_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // State register; reset drops straight back to IDLE from anywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; EVAL outputs also follow the Booth pair
  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    out_valid     = 1'b0;
    out_hi        = 1'b0;
    done          = 1'b0;
    ldX           = 1'b0;
    ldY           = 1'b0;
    ldA           = 1'b0;
    initA         = 1'b0;
    initYminusOne = 1'b0;
    aBarS         = OP_ADD;
    shRA          = 1'b0;
    shRY          = 1'b0;
    ldYminusOne   = 1'b0;
    selL          = 1'b0;
    selR          = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_LDX;
      end
      S_LDX: begin
        ldX     = 1'b1;
        state_d = S_LDY;
      end
      S_LDY: begin
        ldY           = 1'b1;
        initA         = 1'b1;
        initYminusOne = 1'b1;
        cnt_clr       = 1'b1;
        state_d       = S_EVAL;
      end
      S_EVAL: begin
        if (Y0YminusOne == PAIR_SUB) begin
          ldA   = 1'b1;
          aBarS = OP_SUB;
        end else if (Y0YminusOne == PAIR_ADD) begin
          ldA   = 1'b1;
          aBarS = OP_ADD;
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shRA        = 1'b1;
        shRY        = 1'b1;
        ldYminusOne = 1'b1;
        cnt_inc     = 1'b1;
        state_d     = cnt_last ? S_OUT_HI : S_EVAL;
      end
      S_OUT_HI: begin
        selL      = 1'b1;
        out_valid = 1'b1;
        out_hi    = 1'b1;
        state_d   = S_OUT_LO;
      end
      S_OUT_LO: begin
        selR      = 1'b1;
        out_valid = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural Booth datapath driven by the
// controller's pins, directed operand vectors, and a beat scoreboard.
module tb_booth_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] pair;
  logic       ready, out_valid, out_hi, done;
  logic       ldX, ldY, ldA, initA, initYminusOne, aBarS;
  logic       shRA, shRY, ldYminusOne, selL, selR;

  logic [5:0] in_bus = 6'h00;
  logic [5:0] dp_x = 6'h00, dp_a = 6'h00, dp_y = 6'h00;
  logic       dp_ym1 = 1'b0;
  logic       stub = 1'b0;
  logic [5:0] out_bus;
  logic [14:0] ctrl;

  int ntot = 0;
  int npass = 0;
  logic [7:0] sb_q[$];

  booth_controller #(.N(6), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .Y0YminusOne(pair),
    .ready(ready), .out_valid(out_valid), .out_hi(out_hi), .done(done),
    .ldX(ldX), .ldY(ldY), .ldA(ldA), .initA(initA),
    .initYminusOne(initYminusOne), .aBarS(aBarS), .shRA(shRA), .shRY(shRY),
    .ldYminusOne(ldYminusOne), .selL(selL), .selR(selR)
  );

  always #5 clk = ~clk;

  assign pair    = stub ? 2'b00 : {dp_y[0], dp_ym1};
  assign out_bus = selL ? dp_a : (selR ? dp_y : 6'h00);
  assign ctrl    = {ready, out_valid, out_hi, done, ldX, ldY, ldA, initA,
                    initYminusOne, aBarS, shRA, shRY, ldYminusOne, selL, selR};

  // Behavioural datapath reacting to the controller's pins
  always @(posedge clk) begin
    if (ldX) dp_x <= in_bus;
    if (ldY) dp_y <= in_bus;
    if (initA) dp_a <= 6'h00;
    if (initYminusOne) dp_ym1 <= 1'b0;
    if (ldA) dp_a <= aBarS ? (dp_a - dp_x) : (dp_a + dp_x);
    if (shRA) dp_a <= {dp_a[5], dp_a[5:1]};
    if (shRY) dp_y <= {dp_a[0], dp_y[5:1]};
    if (ldYminusOne) dp_ym1 <= dp_y[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected control vector for a run with every Booth pair reading 00
  function automatic logic [14:0] exp_ctrl(input int cyc);
    logic rdy, ov, oh, dn, lx, ly, la, ia, iy, ab, sa, sy, lym, sl, sr;
    {rdy, ov, oh, dn, lx, ly, la, ia, iy, ab, sa, sy, lym, sl, sr} = '0;
    if (cyc == 1) lx = 1'b1;
    else if (cyc == 2) begin ly = 1'b1; ia = 1'b1; iy = 1'b1; end
    else if (cyc >= 3 && cyc <= 14) begin
      if (cyc % 2 == 0) begin sa = 1'b1; sy = 1'b1; lym = 1'b1; end
    end
    else if (cyc == 15) begin sl = 1'b1; ov = 1'b1; oh = 1'b1; end
    else if (cyc == 16) begin sr = 1'b1; ov = 1'b1; dn = 1'b1; end
    else rdy = 1'b1;
    return {rdy, ov, oh, dn, lx, ly, la, ia, iy, ab, sa, sy, lym, sl, sr};
  endfunction

  // Scoreboard monitor: every presented beat must match the next expectation
  always @(negedge clk) begin
    if (out_valid || done) begin
      if (sb_q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_beat: got hi=%0b done=%0b bus=%0h, expected no beat", out_hi, done, out_bus);
      end else begin
        chk("beat", {24'h0, out_hi, done, out_bus}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  // One full operation; pairs lists expected {ldA,aBarS} for each EVAL
  task automatic run_op(input logic [5:0] x, input logic [5:0] y,
                        input logic [5:0] hi, input logic [5:0] lo,
                        input logic [11:0] pairs, input bit full_chk, input bit repulse);
    int k;
    sb_q.push_back({2'b10, hi});
    sb_q.push_back({2'b01, lo});
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(posedge clk); #1;
      start  = (repulse && cyc == 8) ? 1'b1 : 1'b0;
      in_bus = (cyc == 1) ? x : ((cyc == 2) ? y : 6'h00);
      if (full_chk) chk($sformatf("ctrl_c%0d", cyc), {17'h0, ctrl}, {17'h0, exp_ctrl(cyc)});
      else          chk($sformatf("ready_c%0d", cyc), {31'h0, ready}, {31'h0, (cyc == 17)});
      if (cyc >= 3 && cyc <= 13 && cyc % 2 == 1) begin
        k = (cyc - 3) / 2;
        chk($sformatf("eval_%0d", k), {30'h0, ldA, aBarS}, {30'h0, pairs[11 - 2*k -: 2]});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("reset_ctrl", {17'h0, ctrl}, {17'h0, exp_ctrl(0)});
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", {17'h0, ctrl}, {17'h0, exp_ctrl(0)});

    // Stubbed pairs: exact state sequence, no ldA, datapath only shifts
    stub = 1'b1;
    run_op(6'h03, 6'h05, 6'h00, 6'h00, 12'b00_00_00_00_00_00, 1'b1, 1'b0);
    stub = 1'b0;

    // 3 * 5 = 15 : sub, add, sub, add, none, none
    run_op(6'h03, 6'h05, 6'h00, 6'h0F, 12'b11_10_11_10_00_00, 1'b0, 1'b0);
    // -3 * 5 = -15
    run_op(6'h3D, 6'h05, 6'h3F, 6'h31, 12'b11_10_11_10_00_00, 1'b0, 1'b0);
    // 31 * -32 = -992
    run_op(6'h1F, 6'h20, 6'h30, 6'h20, 12'b00_00_00_00_00_11, 1'b0, 1'b0);
    // start re-pulsed during SHIFT of iteration 3 is ignored
    run_op(6'h03, 6'h05, 6'h00, 6'h0F, 12'b11_10_11_10_00_00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an EVAL cycle
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; in_bus = 6'h03;
    @(posedge clk); #1; in_bus = 6'h05;
    @(posedge clk); #1; in_bus = 6'h00;
    chk("pre_reset_ldX", {31'h0, ldX}, 32'h0);
    #2; rst = 1'b1;
    #1;
    chk("async_reset_ctrl", {17'h0, ctrl}, {17'h0, exp_ctrl(0)});
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'h0, ready}, 32'h1);
    run_op(6'h03, 6'h05, 6'h00, 6'h0F, 12'b11_10_11_10_00_00, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
- Moore/Mealy control FSM that sequences the 6-bit radix-2 Booth multiplier datapath.
- Accepts a start request and loads X, then Y, from the shared 6-bit input bus.
- Runs N add/subtract-and-shift iterations, then drives the 12-bit product onto the 6-bit output bus in two beats: A (high half) first, then Y (low half).
- Sits between the top-level handshake and the datapath control pins; it owns no data registers.

Parameters:
- N, 6: operand width = iteration count.
- CNT_W, 3: iteration counter width; must satisfy 2**CNT_W >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Y0YminusOne  input  2  {Y[0], Y[-1]} from the datapath.
- ready  output  1  high in IDLE only.
- out_valid  output  1  high during both output beats.
- out_hi  output  1  high on the first output beat (A on the bus), low on the second (Y on the bus).
- done  output  1  one-cycle pulse on the second output beat.
- ldX, ldY, ldA, initA, initYminusOne, aBarS, shRA, shRY, ldYminusOne, selL, selR  output  1 each  datapath controls.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE and the counter clears to 0.
  - All controls, out_valid, out_hi and done go to 0; ready goes to 1.
  - Reset mid-operation abandons the operation with no output beats.
- States: IDLE, LDX, LDY, EVAL, SHIFT, OUT_HI, OUT_LO.
- IDLE:
  - ready=1.
  - start=1 at a rising edge moves to LDX; otherwise stay.
- LDX: ldX=1; inBus must carry X during this cycle. Always moves to LDY.
- LDY:
  - ldY=1, initA=1, initYminusOne=1; inBus carries Y.
  - Counter clears to 0. Moves to EVAL.
- EVAL (combinational on Y0YminusOne):
  - 2'b10: ldA=1, aBarS=1 (A ← A − X).
  - 2'b01: ldA=1, aBarS=0 (A ← A + X).
  - 2'b00 or 2'b11: ldA=0, aBarS=0.
  - Moves to SHIFT.
- SHIFT:
  - shRA=1, shRY=1, ldYminusOne=1; counter increments.
  - If counter == N−1 before the increment, move to OUT_HI; else move to EVAL.
- OUT_HI: selL=1, out_valid=1, out_hi=1. Moves to OUT_LO.
- OUT_LO: selR=1, out_valid=1, done=1. Moves to IDLE.
- Exclusivity:
  - selL and selR are never high in the same cycle.
  - ldA and shRA are never high in the same cycle.
  - All controls not listed for a state are 0.
- Latency:
  - start is sampled at edge 0; LDX is cycle 1, LDY is cycle 2.
  - EVAL/SHIFT pairs run in cycles 3..2N+2.
  - OUT_HI is cycle 2N+3 and OUT_LO is cycle 2N+4; for N=6 these are cycles 15 and 16.
  - ready returns at cycle 2N+5.
- start while not IDLE is ignored and not queued.
- start held high continuously produces back-to-back operations with one IDLE cycle between them.
- Counter wrap is never reached: it clears in LDY and stops at N.
- Overflow: X = −2^(N−1) is outside the supported operand range (A overflows); the controller does not detect it.

Decomposition:
- booth_pkg holds:
  - the state enum;
  - localparams for the Booth pair codes (PAIR_SUB=2'b10, PAIR_ADD=2'b01);
  - the aBarS encodings (OP_ADD=0, OP_SUB=1).
- One sub-module, booth_iter_counter: CNT_W-bit counter with clr and inc inputs and a last flag (count == N−1), async reset.
- FSM and output decode stay in booth_controller.

Test Plan:
- Reset → ready=1, all controls 0. Pulse start with a Y0YminusOne stub held at 2'b00 → exact state sequence LDX, LDY, (EVAL, SHIFT)×6, OUT_HI, OUT_LO. ldA never asserted; done pulses once at cycle 16.
- Integrated with the datapath, X=3, Y=5 → EVAL decisions are sub, add, sub, add, none, none. The two beats are A=6'h00 (out_hi=1), then Y=6'h0F.
- X=6'h3D (−3), Y=5 → beats 6'h3F then 6'h31 (−15 = 12'hFF1).
- X=31, Y=6'h20 (−32) → beats 6'h30 then 6'h20 (−992 = 12'hC20).
- start re-pulsed during SHIFT of iteration 3 → ignored. Sequence and result unchanged; ready stays 0 until cycle 17.
- rst asserted asynchronously mid-EVAL (between edges) → outputs clear immediately and ready=1. A new start after release runs X=3, Y=5 correctly to 6'h00, 6'h0F.
